// File: rtl/ps2_event_rx.sv
`timescale 1ns/1ps
// ps2_event_rx
// PS/2 keyboard receiver. It synchronises and debounces the raw PS/2 clock,
// deframes 11-bit packets (start, 8 data LSB-first, odd parity, stop),
// folds the E0/F0 prefixes into extended/break flags and buffers the
// resulting key events in a small FIFO for the VGA-side consumer.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   ps2clk     raw PS/2 clock (asynchronous)
//   ps2data    raw PS/2 data (asynchronous)
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head event (pop on evt_valid & evt_ready)
//   evt_code   scancode of the head event (0 when empty)
//   evt_ext    head event was E0-prefixed (0 when empty)
//   evt_break  head event is a key release (0 when empty)
//   frame_err  one-cycle pulse on parity, stop-bit or timeout error
//   overflow   one-cycle pulse when an event is dropped on a full FIFO
module ps2_event_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_MODE    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic           MAKE_TOO  = (REPORT_MODE != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           filt_level, filt_prev, fall;
    logic [FCW-1:0] filt_cnt;

    rx_state_t      state, state_nxt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [TCW-1:0] to_cnt;
    logic           shift_en, par_en, stop_good, stop_bad, timeout;
    logic           byte_done;
    logic [7:0]     byte_val;

    logic           ext_flag, brk_flag, ext_nxt, brk_nxt, push_req;
    logic [9:0]     mem [FIFO_DEPTH];
    logic [9:0]     head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           pop, push, full;

    // Two-flop synchronisers; both lines idle high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only follows the synced clock after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts
    // the count, so short glitches never reach the receiver.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_prev <= filt_level;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_level <= clk_s2;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    assign fall = filt_prev & ~filt_level;

    // Frame receiver next-state logic. The timeout check sits ahead of the
    // fall handling so a stop edge landing on the timeout cycle is aborted.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        timeout   = 1'b0;
        if (state != IDLE && to_cnt == TO_LAST) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) state_nxt = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    if (dat_s2 && (^{shreg, par_bit})) stop_good = 1'b1;
                    else                               stop_bad  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Receiver registers: shifting, parity capture, timeout counter and the
    // registered byte_done / frame_err pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_done <= 1'b0;
            byte_val  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_done <= stop_good;
            frame_err <= stop_bad | timeout;
            if (stop_good) byte_val <= shreg;
            if (shift_en) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (state == IDLE) begin
                bit_cnt <= '0;
            end
            if (par_en) par_bit <= dat_s2;
            if (fall || state == IDLE) to_cnt <= '0;
            else                       to_cnt <= to_cnt + TCW'(1);
        end
    end

    // Prefix decoding. Errors wipe any pending prefix; a plain code
    // consumes the prefixes and becomes an event.
    always_comb begin
        ext_nxt  = ext_flag;
        brk_nxt  = brk_flag;
        push_req = 1'b0;
        if (stop_bad || timeout) begin
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
        end else if (byte_done) begin
            case (byte_val)
                8'hE0: ext_nxt = 1'b1;
                8'hF0: brk_nxt = 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                    ext_nxt = 1'b0;
                    brk_nxt = 1'b0;
                end
                default: begin
                    push_req = brk_flag | MAKE_TOO;
                    ext_nxt  = 1'b0;
                    brk_nxt  = 1'b0;
                end
            endcase
        end
    end

    // A full FIFO can still accept a push when the head is popped in the
    // same cycle; only a push with no pop on a full FIFO is dropped.
    assign pop  = evt_valid & evt_ready;
    assign full = (count == FIFO_FULL);
    assign push = push_req & (~full | pop);

    // Prefix flags, FIFO pointers/occupancy and the overflow pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ext_flag <= ext_nxt;
            brk_flag <= brk_nxt;
            overflow <= push_req & full & ~pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Event storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {byte_val, ext_flag, brk_flag};
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? head[9:2] : 8'h00;
    assign evt_ext   = evt_valid ? head[1]   : 1'b0;
    assign evt_break = evt_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_ps2_event_rx.sv
`timescale 1ns/1ps
// tb_ps2_event_rx
// Self-checking bench for ps2_event_rx. Two instances share the PS/2 lines:
// dut_m0 reports break events only, dut_m1 reports make and break events.
// Events popped from each FIFO are collected into queues and compared with
// expectations from a vector table, hand-written sequences and a
// behavioural decode model driven by random bytes.
module tb_ps2_event_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int FIFO_DEPTH     = 4;
    localparam int HALF           = 30;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic        m0_has;
        logic [9:0]  m0_ev;
        logic        m1_has;
        logic [9:0]  m1_ev;
    } vec_t;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2clk   = 1'b1;
    logic       ps2data  = 1'b1;
    logic       ready_m0 = 1'b1;
    logic       ready_m1 = 1'b1;
    logic       valid_m0, ext_m0, brk_m0, ferr_m0, ovf_m0;
    logic       valid_m1, ext_m1, brk_m1, ferr_m1, ovf_m1;
    logic [7:0] code_m0, code_m1;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int last_fall_cyc = 0;
    int err_cnt_m0 = 0, err_cnt_m1 = 0;
    int ovf_cnt_m0 = 0, ovf_cnt_m1 = 0;
    int err_cyc_m1 = 0;
    int rise_cyc_m0 = 0, hi_cnt_m0 = 0;
    int model_errs = 0;
    logic prev_valid_m0 = 1'b0;
    logic m_ext = 1'b0, m_brk = 1'b0;

    logic [9:0] got_m0[$], got_m1[$], exp_m0[$], exp_m1[$];
    vec_t vecs[8];

    ps2_event_rx #(
        .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .REPORT_MODE(0)
    ) dut_m0 (
        .clock(clock), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .evt_valid(valid_m0), .evt_ready(ready_m0), .evt_code(code_m0),
        .evt_ext(ext_m0), .evt_break(brk_m0), .frame_err(ferr_m0),
        .overflow(ovf_m0)
    );

    ps2_event_rx #(
        .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .REPORT_MODE(1)
    ) dut_m1 (
        .clock(clock), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .evt_valid(valid_m1), .evt_ready(ready_m1), .evt_code(code_m1),
        .evt_ext(ext_m1), .evt_break(brk_m1), .frame_err(ferr_m1),
        .overflow(ovf_m1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor on the falling edge: collect popped events, count pulses and
    // note when dut_m0's valid rises.
    always @(negedge clock) begin
        if (valid_m0 && ready_m0) got_m0.push_back({code_m0, ext_m0, brk_m0});
        if (valid_m1 && ready_m1) got_m1.push_back({code_m1, ext_m1, brk_m1});
        if (ferr_m0) err_cnt_m0++;
        if (ferr_m1) begin
            err_cnt_m1++;
            err_cyc_m1 = cyc;
        end
        if (ovf_m0) ovf_cnt_m0++;
        if (ovf_m1) ovf_cnt_m1++;
        if (valid_m0 && !prev_valid_m0) rise_cyc_m0 = cyc;
        if (valid_m0) hi_cnt_m0++;
        prev_valid_m0 = valid_m0;
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("[TB] FAIL watchdog: got cycle %0d, required finish earlier", cyc);
        n_mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual,
                               input int lo, input int hi);
        n_compared++;
        if (actual < lo || actual > hi) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Drive bits LSB first: data changes mid-high, clock low for HALF cycles.
    // glitch_after inserts a 3-cycle low pulse in the high phase after that bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input int glitch_after);
        for (int i = 0; i < nbits; i++) begin
            tick(HALF / 2);
            ps2data = bits[i];
            tick(HALF / 2);
            ps2clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2clk = 1'b1;
            if (i == glitch_after) begin
                tick(18);
                ps2clk = 1'b0;
                tick(3);
                ps2clk = 1'b1;
            end
        end
        tick(HALF / 2);
        ps2data = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic bad_par,
                                  input logic bad_stop, input int glitch_after);
        logic [10:0] frame;
        frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(frame, 11, glitch_after);
        tick(20);
    endtask

    // Reference decode: what the keyboard byte stream means as key events.
    task automatic model_byte(input logic [7:0] b, input logic good);
        logic [9:0] ev;
        if (!good) begin
            model_errs++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                     b == 8'h00 || b == 8'hFF) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            ev = {b, m_ext, m_brk};
            exp_m1.push_back(ev);
            if (m_brk) exp_m0.push_back(ev);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic compare_queues(input string tag);
        check_output({tag, " m0 event count"}, got_m0.size(), exp_m0.size());
        for (int i = 0; i < got_m0.size() && i < exp_m0.size(); i++)
            check_output($sformatf("%s m0 event %0d", tag, i), got_m0[i], exp_m0[i]);
        check_output({tag, " m1 event count"}, got_m1.size(), exp_m1.size());
        for (int i = 0; i < got_m1.size() && i < exp_m1.size(); i++)
            check_output($sformatf("%s m1 event %0d", tag, i), got_m1[i], exp_m1[i]);
        got_m0.delete();
        got_m1.delete();
        exp_m0.delete();
        exp_m1.delete();
    endtask

    initial begin
        int base_e0, base_e1, base_o0, base_o1;
        logic [7:0] bt;
        logic bad;
        int sel;
        bit done;

        // {bytes (first in [7:0]), count, m0 expected, m1 expected}
        vecs[0] = '{24'h00001C, 1, 1'b0, 10'h000, 1'b1, {8'h1C, 2'b00}};
        vecs[1] = '{24'h001CF0, 2, 1'b1, {8'h1C, 2'b01}, 1'b1, {8'h1C, 2'b01}};
        vecs[2] = '{24'h0075E0, 2, 1'b0, 10'h000, 1'b1, {8'h75, 2'b10}};
        vecs[3] = '{24'h75F0E0, 3, 1'b1, {8'h75, 2'b11}, 1'b1, {8'h75, 2'b11}};
        vecs[4] = '{24'h0000AA, 1, 1'b0, 10'h000, 1'b0, 10'h000};
        vecs[5] = '{24'h2CFAE0, 3, 1'b0, 10'h000, 1'b1, {8'h2C, 2'b00}};
        vecs[6] = '{24'h4B00F0, 3, 1'b0, 10'h000, 1'b1, {8'h4B, 2'b00}};
        vecs[7] = '{24'h11E0F0, 3, 1'b1, {8'h11, 2'b11}, 1'b1, {8'h11, 2'b11}};

        // Reset state.
        reset = 1'b0;
        tick(5);
        check_output("reset m0 valid", valid_m0, 0);
        check_output("reset m0 code", code_m0, 0);
        check_output("reset m0 ext", ext_m0, 0);
        check_output("reset m0 break", brk_m0, 0);
        check_output("reset m0 frame_err", ferr_m0, 0);
        check_output("reset m0 overflow", ovf_m0, 0);
        check_output("reset m1 valid", valid_m1, 0);
        check_output("reset m1 code", code_m1, 0);
        check_output("reset m1 ext", ext_m1, 0);
        check_output("reset m1 break", brk_m1, 0);
        check_output("reset m1 frame_err", ferr_m1, 0);
        check_output("reset m1 overflow", ovf_m1, 0);
        reset = 1'b1;
        tick(20);

        // Table-driven prefix decoding.
        for (int v = 0; v < 8; v++) begin
            base_e0 = err_cnt_m0;
            base_e1 = err_cnt_m1;
            hi_cnt_m0 = 0;
            for (int k = 0; k < vecs[v].n; k++)
                apply_stimulus(vecs[v].bytes[8*k +: 8], 1'b0, 1'b0, -1);
            if (vecs[v].m0_has) exp_m0.push_back(vecs[v].m0_ev);
            if (vecs[v].m1_has) exp_m1.push_back(vecs[v].m1_ev);
            compare_queues($sformatf("vec%0d", v));
            check_output($sformatf("vec%0d m1 frame_err", v), err_cnt_m1 - base_e1, 0);
            check_output($sformatf("vec%0d m0 frame_err", v), err_cnt_m0 - base_e0, 0);
            if (vecs[v].m0_has) begin
                check_output($sformatf("vec%0d m0 valid width", v), hi_cnt_m0, 1);
                check_range($sformatf("vec%0d m0 valid latency", v),
                            rise_cyc_m0 - last_fall_cyc, FILTER_LEN + 3, FILTER_LEN + 5);
            end
        end

        // Random byte stream with occasional parity errors against the model.
        base_e0 = err_cnt_m0;
        base_e1 = err_cnt_m1;
        model_errs = 0;
        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      bt = 8'hE0;
            else if (sel == 1) bt = 8'hF0;
            else if (sel == 2) bt = 8'hAA;
            else               bt = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            apply_stimulus(bt, bad, 1'b0, -1);
            model_byte(bt, !bad);
        end
        apply_stimulus(8'h1C, 1'b0, 1'b0, -1);
        model_byte(8'h1C, 1'b1);
        compare_queues("random");
        check_output("random m1 frame_err count", err_cnt_m1 - base_e1, model_errs);
        check_output("random m0 frame_err count", err_cnt_m0 - base_e0, model_errs);

        // Parity error clears a pending break prefix.
        base_e1 = err_cnt_m1;
        apply_stimulus(8'hF0, 1'b0, 1'b0, -1);
        apply_stimulus(8'h1C, 1'b1, 1'b0, -1);
        apply_stimulus(8'h1C, 1'b0, 1'b0, -1);
        exp_m1.push_back({8'h1C, 2'b00});
        compare_queues("parity");
        check_output("parity frame_err count", err_cnt_m1 - base_e1, 1);

        // Bad stop bit.
        base_e1 = err_cnt_m1;
        apply_stimulus(8'h2C, 1'b0, 1'b1, -1);
        compare_queues("stop");
        check_output("stop frame_err count", err_cnt_m1 - base_e1, 1);

        // Partial frame then silence: timeout abort.
        base_e0 = err_cnt_m0;
        base_e1 = err_cnt_m1;
        send_bits(11'b000_0001_1010, 5, -1);
        done = 1'b0;
        for (int k = 0; k < TIMEOUT_CYCLES + 200 && !done; k++) begin
            tick(1);
            if (err_cnt_m1 != base_e1) done = 1'b1;
        end
        tick(5);
        check_output("timeout frame_err count", err_cnt_m1 - base_e1, 1);
        check_output("timeout m0 frame_err count", err_cnt_m0 - base_e0, 1);
        check_range("timeout delay", err_cyc_m1 - last_fall_cyc,
                    TIMEOUT_CYCLES + FILTER_LEN + 2, TIMEOUT_CYCLES + FILTER_LEN + 4);
        apply_stimulus(8'h32, 1'b0, 1'b0, -1);
        exp_m1.push_back({8'h32, 2'b00});
        compare_queues("after timeout");

        // Overflow: five make codes into a four-entry FIFO with no consumer.
        base_o0 = ovf_cnt_m0;
        base_o1 = ovf_cnt_m1;
        ready_m0 = 1'b0;
        ready_m1 = 1'b0;
        apply_stimulus(8'h15, 1'b0, 1'b0, -1);
        apply_stimulus(8'h1D, 1'b0, 1'b0, -1);
        apply_stimulus(8'h24, 1'b0, 1'b0, -1);
        apply_stimulus(8'h2D, 1'b0, 1'b0, -1);
        check_output("overflow before fifth", ovf_cnt_m1 - base_o1, 0);
        apply_stimulus(8'h2C, 1'b0, 1'b0, -1);
        check_output("overflow on fifth", ovf_cnt_m1 - base_o1, 1);
        check_output("overflow m0", ovf_cnt_m0 - base_o0, 0);
        check_output("full head valid", valid_m1, 1);
        check_output("full head code", code_m1, 8'h15);
        check_output("m0 empty valid", valid_m0, 0);
        ready_m0 = 1'b1;
        ready_m1 = 1'b1;
        tick(10);
        exp_m1.push_back({8'h15, 2'b00});
        exp_m1.push_back({8'h1D, 2'b00});
        exp_m1.push_back({8'h24, 2'b00});
        exp_m1.push_back({8'h2D, 2'b00});
        compare_queues("drain");

        // Clock glitches: one while idle, one inside a frame.
        base_e1 = err_cnt_m1;
        tick(10);
        ps2clk = 1'b0;
        tick(3);
        ps2clk = 1'b1;
        tick(40);
        apply_stimulus(8'h1C, 1'b0, 1'b0, 3);
        exp_m1.push_back({8'h1C, 2'b00});
        compare_queues("glitch");
        check_output("glitch frame_err count", err_cnt_m1 - base_e1, 0);

        // Reset with a queued event, a pending F0 and a half-received frame.
        base_e1 = err_cnt_m1;
        ready_m1 = 1'b0;
        apply_stimulus(8'h1C, 1'b0, 1'b0, -1);
        apply_stimulus(8'hF0, 1'b0, 1'b0, -1);
        send_bits(11'b000_0010_1100, 6, -1);
        check_output("pre-reset m1 valid", valid_m1, 1);
        reset = 1'b0;
        tick(3);
        check_output("mid reset m1 valid", valid_m1, 0);
        check_output("mid reset m1 code", code_m1, 0);
        reset = 1'b1;
        tick(5);
        ready_m1 = 1'b1;
        tick(5);
        apply_stimulus(8'h5A, 1'b0, 1'b0, -1);
        exp_m1.push_back({8'h5A, 2'b00});
        compare_queues("after reset");
        check_output("after reset frame_err count", err_cnt_m1 - base_e1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
